// File: rtl/arf_seq_pkg.sv
// Shared encodings for the address-register-file sequencer: register function,
// register selects, out-selects, command opcodes and FSM state codes.
package arf_seq_pkg;

    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    localparam logic [2:0] RS_NONE = 3'b000;
    localparam logic [2:0] RS_AR   = 3'b001;
    localparam logic [2:0] RS_SP   = 3'b010;
    localparam logic [2:0] RS_PC   = 3'b100;
    localparam logic [2:0] RS_ALL  = 3'b111;

    localparam logic [1:0] OS_PC = 2'b00;
    localparam logic [1:0] OS_SP = 2'b01;
    localparam logic [1:0] OS_AR = 2'b10;

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_FETCH  = 3'b001;
    localparam logic [2:0] CMD_PUSH   = 3'b010;
    localparam logic [2:0] CMD_POP    = 3'b011;
    localparam logic [2:0] CMD_JUMP   = 3'b100;
    localparam logic [2:0] CMD_SPINIT = 3'b101;

    typedef logic [3:0] state_t;

    localparam state_t ST_INIT0 = 4'd0;
    localparam state_t ST_INIT1 = 4'd1;
    localparam state_t ST_IDLE  = 4'd2;
    localparam state_t ST_F_RD  = 4'd3;
    localparam state_t ST_F_INC = 4'd4;
    localparam state_t ST_P_DEC = 4'd5;
    localparam state_t ST_P_WR  = 4'd6;
    localparam state_t ST_Q_RD  = 4'd7;
    localparam state_t ST_Q_INC = 4'd8;
    localparam state_t ST_J_LD  = 4'd9;
    localparam state_t ST_ACK   = 4'd10;
    localparam state_t ST_ERR   = 4'd11;

endpackage

// File: rtl/arf_sequencer_if.sv
// Command handshake plus register-file control bundle between control unit,
// sequencer and address register file.
interface arf_sequencer_if;
    logic        CmdValid;
    logic [2:0]  Cmd;
    logic [15:0] Operand;
    logic        CmdReady;
    logic [2:0]  RegSel;
    logic [1:0]  FunSel;
    logic [1:0]  OutCSel;
    logic [1:0]  OutDSel;
    logic [31:0] ArfI;
    logic        MemRd;
    logic        MemWr;
    logic        Done;
    logic        Err;

    modport master (
        output CmdValid, Cmd, Operand,
        input  CmdReady, RegSel, FunSel, OutCSel, OutDSel, ArfI, MemRd, MemWr, Done, Err
    );

    modport slave (
        input  CmdValid, Cmd, Operand,
        output CmdReady, RegSel, FunSel, OutCSel, OutDSel, ArfI, MemRd, MemWr, Done, Err
    );
endinterface

// File: rtl/arf_stack_depth.sv
// Saturating stack-depth counter (0..Depth) with full/empty flags.
module arf_stack_depth #(
    parameter int unsigned Depth = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic full_o,
    output logic empty_o
);
    logic [7:0] depth_q, depth_d;

    assign full_o  = (depth_q == 8'(Depth));
    assign empty_o = (depth_q == 8'd0);

    always_comb begin
        depth_d = depth_q;
        if (clr_i) begin
            depth_d = 8'd0;
        end else if (inc_i && !full_o) begin
            depth_d = depth_q + 8'd1;
        end else if (dec_i && !empty_o) begin
            depth_d = depth_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q <= 8'd0;
        end else begin
            depth_q <= depth_d;
        end
    end
endmodule

// File: rtl/arf_sequencer.sv
// Command sequencer producing per-cycle AR/SP/PC controls and memory strobes.
// Define ARF_SEQ_STACK_GUARD_EN to build the depth guard that rejects overflow/underflow.
module arf_sequencer
    import arf_seq_pkg::*;
#(
    parameter logic [15:0] STACK_TOP   = 16'h00FF,
    parameter int unsigned STACK_DEPTH = 16
) (
    input logic            Clock,
    input logic            Reset,
    arf_sequencer_if.slave bus
);
    state_t      state_q, state_d;
    logic [2:0]  cmd_q;
    logic [15:0] operand_q;
    logic        accept;
    logic        push_blk, pop_blk;

    assign accept = bus.CmdValid && (state_q == ST_IDLE);

`ifdef ARF_SEQ_STACK_GUARD_EN
    logic full, empty;

    arf_stack_depth #(
        .Depth (STACK_DEPTH)
    ) u_depth (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .inc_i   (state_q == ST_P_WR),
        .dec_i   (state_q == ST_Q_INC),
        .clr_i   (state_q == ST_INIT1),
        .full_o  (full),
        .empty_o (empty)
    );

    assign push_blk = full;
    assign pop_blk  = empty;
`else
    logic unused_depth_cfg;
    assign unused_depth_cfg = ^STACK_DEPTH;
    assign push_blk         = 1'b0;
    assign pop_blk          = 1'b0;
`endif

    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            ST_INIT0: state_d = ST_INIT1;
            ST_INIT1: state_d = ST_IDLE;
            ST_IDLE: begin
                state_d = ST_IDLE;
                if (bus.CmdValid) begin
                    case (bus.Cmd)
                        CMD_FETCH:  state_d = ST_F_RD;
                        CMD_PUSH:   state_d = push_blk ? ST_ERR : ST_P_DEC;
                        CMD_POP:    state_d = pop_blk ? ST_ERR : ST_Q_RD;
                        CMD_JUMP:   state_d = ST_J_LD;
                        CMD_SPINIT: state_d = ST_INIT1;
                        default:    state_d = ST_ACK;
                    endcase
                end
            end
            ST_F_RD: state_d = ST_F_INC;
            ST_P_DEC: state_d = ST_P_WR;
            ST_Q_RD: state_d = ST_Q_INC;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_INIT0;
            cmd_q     <= CMD_NOP;
            operand_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q     <= bus.Cmd;
                operand_q <= bus.Operand;
            end
        end
    end

    logic [2:0]  reg_sel;
    logic [1:0]  fun_sel;
    logic [1:0]  out_sel;
    logic [15:0] arf_lo;
    logic        mem_rd, mem_wr, cmd_ready, done, err;

    // Moore decode; Reset forces every output low in the same cycle.
    always_comb begin
        reg_sel   = RS_NONE;
        fun_sel   = FS_DEC;
        out_sel   = OS_PC;
        arf_lo    = 16'h0000;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        if (!Reset) begin
            case (state_q)
                ST_INIT0: begin
                    reg_sel = RS_ALL;
                    fun_sel = FS_CLR;
                end
                ST_INIT1: begin
                    reg_sel = RS_SP;
                    fun_sel = FS_LOAD;
                    arf_lo  = STACK_TOP;
                    done    = (cmd_q == CMD_SPINIT);
                end
                ST_IDLE:  cmd_ready = 1'b1;
                ST_F_RD: begin
                    out_sel = OS_PC;
                    mem_rd  = 1'b1;
                end
                ST_F_INC: begin
                    reg_sel = RS_PC;
                    fun_sel = FS_INC;
                    done    = 1'b1;
                end
                ST_P_DEC: begin
                    reg_sel = RS_SP;
                    fun_sel = FS_DEC;
                end
                ST_P_WR: begin
                    out_sel = OS_SP;
                    mem_wr  = 1'b1;
                    done    = 1'b1;
                end
                ST_Q_RD: begin
                    out_sel = OS_SP;
                    mem_rd  = 1'b1;
                end
                ST_Q_INC: begin
                    reg_sel = RS_SP;
                    fun_sel = FS_INC;
                    done    = 1'b1;
                end
                ST_J_LD: begin
                    reg_sel = RS_PC;
                    fun_sel = FS_LOAD;
                    arf_lo  = operand_q;
                    done    = 1'b1;
                end
                ST_ACK:   done = 1'b1;
`ifdef ARF_SEQ_STACK_GUARD_EN
                ST_ERR:   err = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.CmdReady = cmd_ready;
    assign bus.RegSel   = reg_sel;
    assign bus.FunSel   = fun_sel;
    assign bus.OutCSel  = out_sel;
    assign bus.OutDSel  = out_sel;
    assign bus.ArfI     = {16'h0000, arf_lo};
    assign bus.MemRd    = mem_rd;
    assign bus.MemWr    = mem_wr;
    assign bus.Done     = done;
    assign bus.Err      = err;
endmodule

// File: tb/tb_arf_sequencer.sv
// Directed bench for arf_sequencer with a behavioural AR/SP/PC register-file model.
module tb_arf_sequencer;
    import arf_seq_pkg::*;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    arf_sequencer_if bus ();

    arf_sequencer #(
        .STACK_TOP   (16'h00FF),
        .STACK_DEPTH (16)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Register-file model: controls sampled mid-low-phase, applied at the rising edge.
    logic [15:0] m_ar = 16'hDEAD, m_sp = 16'hBEEF, m_pc = 16'hCAFE;
    logic [2:0]  s_rs = 3'b000;
    logic [1:0]  s_fs = 2'b00;
    logic [15:0] s_i  = 16'h0000;

    always @(negedge Clock) begin
        #2;
        s_rs = bus.RegSel;
        s_fs = bus.FunSel;
        s_i  = bus.ArfI[15:0];
    end

    function automatic logic [15:0] apply(input logic [15:0] v, input logic [1:0] fs,
                                          input logic [15:0] d);
        case (fs)
            2'b00:   return v - 16'd1;
            2'b01:   return v + 16'd1;
            2'b10:   return d;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (s_rs[0]) m_ar <= apply(m_ar, s_fs, s_i);
        if (s_rs[1]) m_sp <= apply(m_sp, s_fs, s_i);
        if (s_rs[2]) m_pc <= apply(m_pc, s_fs, s_i);
    end

    function automatic logic [15:0] mem_addr();
        case (bus.OutDSel)
            2'b00:   return m_pc;
            2'b01:   return m_sp;
            default: return m_ar;
        endcase
    endfunction

    function automatic logic [13:0] outs();
        return {bus.CmdReady, bus.RegSel, bus.FunSel, bus.OutCSel, bus.OutDSel,
                bus.MemRd, bus.MemWr, bus.Done, bus.Err};
    endfunction

    // Expected control vector; OutCSel always mirrors OutDSel.
    function automatic logic [13:0] ov(input logic rdy, input logic [2:0] rs, input logic [1:0] fs,
                                       input logic [1:0] os, input logic rd, input logic wr,
                                       input logic dn, input logic er);
        return {rdy, rs, fs, os, os, rd, wr, dn, er};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_outs(input string tag, input logic [13:0] exp);
        check(tag, 32'(outs()), 32'(exp));
    endtask

    localparam logic [13:0] IdleOv = 14'b1_000_00_00_00_0000;

    // Called with Reset already due; holds it, then checks the INIT0/INIT1/IDLE walk.
    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        repeat (cycles) begin
            @(negedge Clock);
            check_outs("rst_outs", 14'd0);
            check("rst_arfi", bus.ArfI, 32'h0);
        end
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check_outs("init0", ov(1'b0, 3'b111, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge Clock);
        check_outs("init1", ov(1'b0, 3'b010, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        check("init1_arfi", bus.ArfI, 32'h0000_00FF);
        @(negedge Clock);
        check_outs("init_idle", IdleOv);
        check("init_sp", 32'(m_sp), 32'h00FF);
        check("init_pc", 32'(m_pc), 32'h0000);
        check("init_ar", 32'(m_ar), 32'h0000);
    endtask

    // Entered at a falling edge; returns at the falling edge inside the first step.
    task automatic issue(input logic [2:0] cmd, input logic [15:0] op);
        int n = 0;
        while (bus.CmdReady !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check("cmd_ready", 32'(bus.CmdReady), 32'h1);
        bus.CmdValid = 1'b1;
        bus.Cmd      = cmd;
        bus.Operand  = op;
        @(posedge Clock);
        #1 bus.CmdValid = 1'b0;
        @(negedge Clock);
    endtask

    task automatic push_seq(input logic [15:0] exp_sp);
        issue(CMD_PUSH, 16'h0000);
        check_outs("p_dec", ov(1'b0, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge Clock);
        check_outs("p_wr", ov(1'b0, 3'b000, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0));
        check("p_addr", 32'(mem_addr()), 32'(exp_sp));
        @(negedge Clock);
    endtask

    task automatic pop_seq(input logic [15:0] exp_addr, input logic [15:0] exp_sp);
        issue(CMD_POP, 16'h0000);
        check_outs("q_rd", ov(1'b0, 3'b000, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
        check("q_addr", 32'(mem_addr()), 32'(exp_addr));
        @(negedge Clock);
        check_outs("q_inc", ov(1'b0, 3'b010, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge Clock);
        check("q_sp", 32'(m_sp), 32'(exp_sp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.CmdValid = 1'b0;
        bus.Cmd      = 3'b000;
        bus.Operand  = 16'h0000;
        do_reset(3);

        issue(CMD_FETCH, 16'h0000);
        check_outs("f_rd", ov(1'b0, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
        check("f_addr", 32'(mem_addr()), 32'h0000);
        @(negedge Clock);
        check_outs("f_inc", ov(1'b0, 3'b100, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge Clock);
        check_outs("f_idle", IdleOv);
        check("f_pc", 32'(m_pc), 32'h0001);

        issue(CMD_JUMP, 16'h1234);
        check_outs("j_ld", ov(1'b0, 3'b100, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        check("j_arfi", bus.ArfI, 32'h0000_1234);
        @(negedge Clock);
        check("j_pc", 32'(m_pc), 32'h1234);
        issue(CMD_FETCH, 16'h0000);
        check("f2_addr", 32'(mem_addr()), 32'h1234);
        @(negedge Clock);
        check_outs("f2_inc", ov(1'b0, 3'b100, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge Clock);
        check("f2_pc", 32'(m_pc), 32'h1235);

        push_seq(16'h00FE);
        push_seq(16'h00FD);
        pop_seq(16'h00FD, 16'h00FE);

        issue(CMD_NOP, 16'h0000);
        check_outs("nop_ack", ov(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge Clock);
        issue(3'b111, 16'h0000);
        check_outs("undef_ack", ov(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        @(negedge Clock);

        issue(CMD_SPINIT, 16'h0000);
        check_outs("spinit", ov(1'b0, 3'b010, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        check("spinit_arfi", bus.ArfI, 32'h0000_00FF);
        @(negedge Clock);
        check_outs("spinit_idle", IdleOv);
        check("spinit_sp", 32'(m_sp), 32'h00FF);

`ifdef ARF_SEQ_STACK_GUARD_EN
        issue(CMD_POP, 16'h0000);
        check_outs("pop_err", ov(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge Clock);
        check_outs("pop_err_idle", IdleOv);
        check("pop_err_sp", 32'(m_sp), 32'h00FF);
        for (int i = 0; i < 16; i++) push_seq(16'(16'h00FE - i));
        check("full_sp", 32'(m_sp), 32'h00EF);
        issue(CMD_PUSH, 16'h0000);
        check_outs("push_err", ov(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge Clock);
        check_outs("push_err_idle", IdleOv);
        check("push_err_sp", 32'(m_sp), 32'h00EF);
        pop_seq(16'h00EF, 16'h00F0);
`else
        pop_seq(16'h00FF, 16'h0100);
`endif

        issue(CMD_PUSH, 16'h0000);
        check_outs("rst_p_dec", ov(1'b0, 3'b010, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        do_reset(2);
`ifdef ARF_SEQ_STACK_GUARD_EN
        issue(CMD_POP, 16'h0000);
        check_outs("rst_depth0", ov(1'b0, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        @(negedge Clock);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
